// File: rtl/sub_sweep_ctrl.sv
// Operand sweeper and result checker for the WIDTH-bit signed subtractor.
// Optional pause input enabled by defining SUB_SWEEP_HOLD_EN.
module sub_sweep_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_o,
    output logic [WIDTH-1:0]     b_o,
    output logic                 op_valid,
    input  logic [WIDTH-1:0]     sub_i,
    input  logic                 flag_i,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     pass_cnt,
    output logic [2*WIDTH:0]     fail_cnt,
    output logic [2*WIDTH:0]     ovf_cnt,
    output logic                 fail_seen,
    output logic [WIDTH-1:0]     first_fail_a,
    output logic [WIDTH-1:0]     first_fail_b
`ifdef SUB_SWEEP_HOLD_EN
    ,
    input  logic                 hold
`endif
);

    localparam int unsigned CW = 2 * WIDTH + 1;
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] exp_sub;
    logic             ovf;
    logic             exp_flag;
    logic             match;
    logic             last_pair;
    logic             stall;

    // Reference model for the pair currently on a_o/b_o.
    always_comb begin
        exp_sub   = a_o - b_o;
        ovf       = (a_o[WIDTH-1] != b_o[WIDTH-1]) && (exp_sub[WIDTH-1] != a_o[WIDTH-1]);
        exp_flag  = !ovf;
        match     = (sub_i == exp_sub) && (flag_i == exp_flag);
        last_pair = (a_o == S_MAX) && (b_o == S_MAX);
    end

`ifdef SUB_SWEEP_HOLD_EN
    // A held cycle presents no live pair, so validity must drop in the same cycle.
    assign stall    = hold;
    assign op_valid = busy && !hold;
`else
    assign stall    = 1'b0;
    assign op_valid = busy;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_o          <= '0;
            b_o          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            ovf_cnt      <= '0;
            fail_seen    <= 1'b0;
            first_fail_a <= '0;
            first_fail_b <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= RUN;
                        busy         <= 1'b1;
                        a_o          <= S_MIN;
                        b_o          <= S_MIN;
                        pass_cnt     <= '0;
                        fail_cnt     <= '0;
                        ovf_cnt      <= '0;
                        fail_seen    <= 1'b0;
                        first_fail_a <= '0;
                        first_fail_b <= '0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (match) begin
                            pass_cnt <= pass_cnt + CW'(1);
                        end else begin
                            fail_cnt <= fail_cnt + CW'(1);
                            if (!fail_seen) begin
                                fail_seen    <= 1'b1;
                                first_fail_a <= a_o;
                                first_fail_b <= b_o;
                            end
                        end
                        if (ovf) begin
                            ovf_cnt <= ovf_cnt + CW'(1);
                        end
                        // Operands stay on the final pair once the sweep ends.
                        if (last_pair) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (b_o == S_MAX) begin
                            b_o <= S_MIN;
                            a_o <= a_o + WIDTH'(1);
                        end else begin
                            b_o <= b_o + WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_sweep_ctrl.sv
// Directed bench for sub_sweep_ctrl with a behavioural subtractor that can inject faults.
// Define SUB_SWEEP_HOLD_EN to also exercise the hold input.
module tb_sub_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a_o;
    logic [3:0] b_o;
    logic       op_valid;
    logic [3:0] sub_i;
    logic       flag_i;
    logic       busy;
    logic       done;
    logic [8:0] pass_cnt;
    logic [8:0] fail_cnt;
    logic [8:0] ovf_cnt;
    logic       fail_seen;
    logic [3:0] first_fail_a;
    logic [3:0] first_fail_b;
`ifdef SUB_SWEEP_HOLD_EN
    logic       hold;
`endif

    int total;
    int bad;
    int fault_mode;
    int cyc;

    sub_sweep_ctrl #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .a_o          (a_o),
        .b_o          (b_o),
        .op_valid     (op_valid),
        .sub_i        (sub_i),
        .flag_i       (flag_i),
        .busy         (busy),
        .done         (done),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt),
        .ovf_cnt      (ovf_cnt),
        .fail_seen    (fail_seen),
        .first_fail_a (first_fail_a),
        .first_fail_b (first_fail_b)
`ifdef SUB_SWEEP_HOLD_EN
        ,
        .hold         (hold)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Subtractor stand-in: mode 1 corrupts one pair, mode 2 inverts every flag.
    always_comb begin
        logic [3:0] diff;
        logic       v;
        diff   = a_o - b_o;
        v      = (a_o[3] != b_o[3]) && (diff[3] != a_o[3]);
        sub_i  = diff;
        flag_i = !v;
        if (fault_mode == 1 && a_o == 4'h3 && b_o == 4'hE) sub_i = diff ^ 4'h1;
        if (fault_mode == 2) flag_i = v;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one sweep; cycle count includes the edge that samples start.
    task automatic run_sweep(input int hold_at, input int restart_at, output int n);
        n = 0;
        start = 1'b1;
        step();
        n = 1;
        start = 1'b0;
        chk("run_busy", int'(busy), 1);
        chk("run_a0", int'($signed(a_o)), -8);
        chk("run_b0", int'($signed(b_o)), -8);
        while (!done && n < 1000) begin
            start = (n == restart_at);
`ifdef SUB_SWEEP_HOLD_EN
            hold = (hold_at > 0 && n >= hold_at && n < hold_at + 10);
`endif
            step();
            n++;
`ifdef SUB_SWEEP_HOLD_EN
            if (hold_at > 0 && n == hold_at + 1) chk("hold_valid", int'(op_valid), 0);
`endif
            if (hold_at == 0 && n == 2) chk("order_b", int'($signed(b_o)), -7);
            if (hold_at == 0 && n == 17) chk("order_a", int'($signed(a_o)), -7);
        end
        start = 1'b0;
`ifdef SUB_SWEEP_HOLD_EN
        hold = 1'b0;
`endif
        if (!done) chk("done_timeout", 0, 1);
        chk("done_valid", int'(op_valid), 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        fault_mode = 0;
        start = 1'b0;
`ifdef SUB_SWEEP_HOLD_EN
        hold = 1'b0;
`endif
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        chk("rst_a", int'(a_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(op_valid), 0);
        chk("rst_pass", int'(pass_cnt), 0);
        chk("rst_fail_seen", int'(fail_seen), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Clean sweep.
        run_sweep(0, 0, cyc);
        chk("clean_cycle", cyc, 257);
        chk("clean_pass", int'(pass_cnt), 256);
        chk("clean_fail", int'(fail_cnt), 0);
        chk("clean_ovf", int'(ovf_cnt), 64);
        chk("clean_seen", int'(fail_seen), 0);
        step();
        chk("idle_done", int'(done), 0);
        chk("idle_hold_a", int'($signed(a_o)), 7);
        chk("idle_pass", int'(pass_cnt), 256);

        // Single corrupted result at a=3, b=-2.
        fault_mode = 1;
        run_sweep(0, 0, cyc);
        chk("one_fail", int'(fail_cnt), 1);
        chk("one_pass", int'(pass_cnt), 255);
        chk("one_ffa", int'($signed(first_fail_a)), 3);
        chk("one_ffb", int'($signed(first_fail_b)), -2);
        chk("one_seen", int'(fail_seen), 1);
        step();

        // Every flag inverted.
        fault_mode = 2;
        run_sweep(0, 0, cyc);
        chk("flag_fail", int'(fail_cnt), 256);
        chk("flag_pass", int'(pass_cnt), 0);
        chk("flag_ffa", int'($signed(first_fail_a)), -8);
        chk("flag_ffb", int'($signed(first_fail_b)), -8);
        chk("flag_ovf", int'(ovf_cnt), 64);
        step();

        // Reset during the 100th RUN cycle.
        fault_mode = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (99) step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(op_valid), 0);
        chk("abort_a", int'(a_o), 0);
        chk("abort_pass", int'(pass_cnt), 0);
        chk("abort_ffa", int'(first_fail_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("abort_idle", int'(busy), 0);
        run_sweep(0, 0, cyc);
        chk("after_abort_pass", int'(pass_cnt), 256);
        chk("after_abort_seen", int'(fail_seen), 0);
        chk("after_abort_ffa", int'(first_fail_a), 0);
        step();

        // Start pulsed mid-sweep is ignored.
        run_sweep(0, 50, cyc);
        chk("restart_cycle", cyc, 257);
        step();
        chk("restart_idle_busy", int'(busy), 0);

`ifdef SUB_SWEEP_HOLD_EN
        run_sweep(100, 0, cyc);
        chk("hold_cycle", cyc, 267);
        chk("hold_pass", int'(pass_cnt), 256);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
